// File: rtl/uart_pkg.sv
// Shared UART definitions: frame parser state encoding and bit timing.
// Holds the default SOF byte and the receiver bit period.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLen     = 3'd1,
      StPayload = 3'd2,
      StCheck   = 3'd3,
      StHold    = 3'd4
   } parseStateT;

   localparam logic [7:0] SOF_BYTE = 8'hA5;

   localparam int CLKS_PER_BIT = 1250;

   // one full 8N1 character time (start + 8 data + stop)
   localparam int TIMEOUT_DEF = 10 * CLKS_PER_BIT;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, one write port and a
// registered read port. Ports: clk, we/wrAddr/wrData, rdAddr -> rdData.
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wrAddr,
   input  logic [7:0]    wrData,
   input  logic [AW-1:0] rdAddr,
   output logic [7:0]    rdData
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wrAddr] <= wrData;
      end
      rdData <= mem[rdAddr];
   end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser after the UART receiver: SOF, LEN, payload, XOR checksum.
// Ports: clk/rstN/en, rxDv/rxByte in; frameValid/frameLen/rdAddr/rdData/
// frameAck buffer side; errChk/errLen/errTimeout/errOverrun strobes; isIdle.
module uart_frame_parser
   import uart_pkg::*;
#(
   parameter int         MAX_LEN      = 16,
   parameter logic [7:0] SOF          = SOF_BYTE,
   parameter int         TIMEOUT_CLKS = TIMEOUT_DEF,
   localparam int        LW           = $clog2(MAX_LEN + 1),
   localparam int        AW           = $clog2(MAX_LEN)
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          en,
   input  logic          rxDv,
   input  logic [7:0]    rxByte,
   output logic          frameValid,
   output logic [LW-1:0] frameLen,
   input  logic [AW-1:0] rdAddr,
   output logic [7:0]    rdData,
   input  logic          frameAck,
   output logic          errChk,
   output logic          errLen,
   output logic          errTimeout,
   output logic          errOverrun,
   output logic          isIdle
);

   localparam int TW = $clog2(TIMEOUT_CLKS);

   parseStateT    state, stateNext;
   logic [LW-1:0] lenReg, lenNext;
   logic [LW-1:0] idx, idxNext, idxInc;
   logic [7:0]    chk, chkNext;
   logic [TW-1:0] tmr, tmrNext;
   logic          errChkNext, errLenNext;
   logic          errToNext, errOvrNext;
   logic          wrEn;
   logic          tmrExp;
   logic          lenOk;
   logic          rdClr;
   logic [7:0]    bufRd;

   assign idxInc = idx + 1'b1;
   assign tmrExp = (tmr == TW'(TIMEOUT_CLKS - 1));
   assign lenOk  = (rxByte != 8'd0) && (rxByte <= 8'(MAX_LEN));

   always_comb begin
      stateNext  = state;
      lenNext    = lenReg;
      idxNext    = idx;
      chkNext    = chk;
      tmrNext    = '0;
      errChkNext = 1'b0;
      errLenNext = 1'b0;
      errToNext  = 1'b0;
      errOvrNext = 1'b0;
      wrEn       = 1'b0;
      if (!en) begin
         stateNext = StIdle;
      end else begin
         // inter-byte timer, only meaningful inside a frame
         if (state == StLen || state == StPayload ||
             state == StCheck) begin
            if (!rxDv) begin
               if (tmrExp) begin
                  errToNext = 1'b1;
                  stateNext = StIdle;
               end else begin
                  tmrNext = tmr + 1'b1;
               end
            end
         end
         unique case (state)
            StIdle: begin
               if (rxDv && rxByte == SOF) begin
                  stateNext = StLen;
               end
            end
            StLen: begin
               if (rxDv) begin
                  if (lenOk) begin
                     lenNext   = rxByte[LW-1:0];
                     chkNext   = rxByte;
                     idxNext   = '0;
                     stateNext = StPayload;
                  end else begin
                     errLenNext = 1'b1;
                     stateNext  = StIdle;
                  end
               end
            end
            StPayload: begin
               if (rxDv) begin
                  wrEn    = 1'b1;
                  idxNext = idxInc;
                  chkNext = chk ^ rxByte;
                  if (idxInc == lenReg) begin
                     stateNext = StCheck;
                  end
               end
            end
            StCheck: begin
               if (rxDv) begin
                  if (rxByte == chk) begin
                     stateNext = StHold;
                  end else begin
                     errChkNext = 1'b1;
                     stateNext  = StIdle;
                  end
               end
            end
            StHold: begin
               errOvrNext = rxDv;
               if (frameAck) begin
                  stateNext = StIdle;
               end
            end
            default: begin
               stateNext = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state      <= StIdle;
         lenReg     <= '0;
         idx        <= '0;
         chk        <= '0;
         tmr        <= '0;
         errChk     <= 1'b0;
         errLen     <= 1'b0;
         errTimeout <= 1'b0;
         errOverrun <= 1'b0;
         rdClr      <= 1'b1;
      end else begin
         state      <= stateNext;
         lenReg     <= lenNext;
         idx        <= idxNext;
         chk        <= chkNext;
         tmr        <= tmrNext;
         errChk     <= errChkNext;
         errLen     <= errLenNext;
         errTimeout <= errToNext;
         errOverrun <= errOvrNext;
         rdClr      <= 1'b0;
      end
   end

   uart_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk    (clk),
      .we     (wrEn),
      .wrAddr (idx[AW-1:0]),
      .wrData (rxByte),
      .rdAddr (rdAddr),
      .rdData (bufRd)
   );

   // the RAM read register has no reset; mask it until the
   // first read after reset has been captured
   assign rdData     = rdClr ? 8'd0 : bufRd;
   assign frameValid = (state == StHold);
   assign frameLen   = frameValid ? lenReg : '0;
   assign isIdle     = (state == StIdle);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected events are queued
// as bytes are driven and matched by a negedge monitor.
module tb_uart_frame_parser;

   localparam int EV_CHK = 1;
   localparam int EV_LEN = 2;
   localparam int EV_TO  = 3;
   localparam int EV_OVR = 4;
   localparam int EV_VAL = 5;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       en = 1'b1;
   logic       rxDv = 1'b0;
   logic [7:0] rxByte = 8'd0;
   logic       frameValid;
   logic [4:0] frameLen;
   logic [3:0] rdAddr = 4'd0;
   logic [7:0] rdData;
   logic       frameAck = 1'b0;
   logic       errChk;
   logic       errLen;
   logic       errTimeout;
   logic       errOverrun;
   logic       isIdle;

   int         total = 0;
   int         bad = 0;
   int         expQ[$];
   logic [7:0] txBuf[$];
   logic [7:0] sent[$];

   uart_frame_parser dut (
      .clk        (clk),
      .rstN       (rstN),
      .en         (en),
      .rxDv       (rxDv),
      .rxByte     (rxByte),
      .frameValid (frameValid),
      .frameLen   (frameLen),
      .rdAddr     (rdAddr),
      .rdData     (rdData),
      .frameAck   (frameAck),
      .errChk     (errChk),
      .errLen     (errLen),
      .errTimeout (errTimeout),
      .errOverrun (errOverrun),
      .isIdle     (isIdle)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   // event monitor: every strobe / frameValid rise must match the queue
   logic prevFv = 1'b0;
   int   obs[$];
   int   want;
   always @(negedge clk) begin
      obs = {};
      if (errChk)     obs.push_back(EV_CHK);
      if (errLen)     obs.push_back(EV_LEN);
      if (errTimeout) obs.push_back(EV_TO);
      if (errOverrun) obs.push_back(EV_OVR);
      if (frameValid === 1'b1 && !prevFv) obs.push_back(EV_VAL);
      prevFv = (frameValid === 1'b1);
      foreach (obs[i]) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("FAIL mon_unexpected got=%0d want=none", obs[i]);
         end else begin
            want = expQ.pop_front();
            if (obs[i] !== want) begin
               bad++;
               $display("FAIL mon_event got=%0d want=%0d", obs[i], want);
            end
         end
      end
   end

   function automatic logic [7:0] frameChk();
      logic [7:0] x = 8'd0;
      for (int i = 1; i < txBuf.size(); i++) x ^= txBuf[i];
      return x;
   endfunction

   task automatic sendBuf(input int gap);
      sent = txBuf;
      foreach (txBuf[i]) begin
         rxDv = 1'b1;
         rxByte = txBuf[i];
         @(negedge clk);
         rxDv = 1'b0;
         repeat (gap) @(negedge clk);
      end
      txBuf.delete();
   endtask

   task automatic drainCheck(input string name);
      @(posedge clk);
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL %s_leftover got=%0d want=0", name, expQ.size());
      end
      expQ.delete();
      @(negedge clk);
   endtask

   task automatic test_reset;
      rstN = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({frameValid, frameLen, rdData} !== 14'd0) begin
         bad++;
         $display("FAIL rst_out got=%h want=0",
                  {frameValid, frameLen, rdData});
      end
      total++;
      if ({errChk, errLen, errTimeout, errOverrun, isIdle}
          !== 5'b00001) begin
         bad++;
         $display("FAIL rst_flags got=%b want=00001",
                  {errChk, errLen, errTimeout, errOverrun, isIdle});
      end
      rstN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_frame;
      txBuf = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
      txBuf.push_back(frameChk());
      total++;
      if (txBuf[5] !== 8'h03) begin
         bad++;
         $display("FAIL good_model got=%h want=03", txBuf[5]);
      end
      expQ.push_back(EV_VAL);
      sendBuf(0);
      total++;
      if (frameValid !== 1'b1 || frameLen !== 5'd3) begin
         bad++;
         $display("FAIL good_valid got=%b/%0d want=1/3",
                  frameValid, frameLen);
      end
      for (int a = 0; a < 3; a++) begin
         rdAddr = 4'(a);
         @(negedge clk);
         total++;
         if (rdData !== sent[2 + a]) begin
            bad++;
            $display("FAIL good_rd%0d got=%h want=%h",
                     a, rdData, sent[2 + a]);
         end
      end
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
      total++;
      if (frameValid !== 1'b0 || isIdle !== 1'b1) begin
         bad++;
         $display("FAIL good_ack got=%b%b want=01", frameValid, isIdle);
      end
      drainCheck("good");
   endtask

   task automatic test_bad_length;
      logic [7:0] lens[2];
      lens[0] = 8'h00;
      lens[1] = 8'h11;
      for (int k = 0; k < 2; k++) begin
         txBuf = {8'hA5, lens[k]};
         expQ.push_back(EV_LEN);
         sendBuf(0);
         total++;
         if (errLen !== 1'b1 || isIdle !== 1'b1 || frameValid !== 1'b0) begin
            bad++;
            $display("FAIL badlen%0d got=%b%b%b want=110",
                     k, errLen, isIdle, frameValid);
         end
      end
      drainCheck("badlen");
   endtask

   task automatic test_bad_checksum;
      txBuf = {8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
      expQ.push_back(EV_CHK);
      sendBuf(0);
      total++;
      if (errChk !== 1'b1 || isIdle !== 1'b1) begin
         bad++;
         $display("FAIL badchk got=%b%b want=11", errChk, isIdle);
      end
      txBuf = {8'hA5, 8'h01, 8'h5A};
      txBuf.push_back(frameChk());
      expQ.push_back(EV_VAL);
      rdAddr = 4'd0;
      sendBuf(0);
      @(negedge clk);
      total++;
      if (frameValid !== 1'b1 || rdData !== 8'h5A) begin
         bad++;
         $display("FAIL badchk_next got=%b/%h want=1/5a",
                  frameValid, rdData);
      end
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
      drainCheck("badchk");
   endtask

   task automatic test_timeout;
      txBuf = {8'hA5, 8'h02, 8'hAA};
      sendBuf(0);
      repeat (12499) @(negedge clk);
      total++;
      if (errTimeout !== 1'b0 || isIdle !== 1'b0) begin
         bad++;
         $display("FAIL to_early got=%b%b want=00", errTimeout, isIdle);
      end
      expQ.push_back(EV_TO);
      @(negedge clk);
      total++;
      if (errTimeout !== 1'b1 || isIdle !== 1'b1) begin
         bad++;
         $display("FAIL to_fire got=%b%b want=11", errTimeout, isIdle);
      end
      @(negedge clk);
      total++;
      if (errTimeout !== 1'b0) begin
         bad++;
         $display("FAIL to_once got=%b want=0", errTimeout);
      end
      txBuf = {8'hA5, 8'h02, 8'hAA};
      sendBuf(0);
      repeat (12499) @(negedge clk);
      txBuf = {8'hA5, 8'h02, 8'hAA, 8'h55};
      txBuf.push_back(frameChk());
      txBuf = txBuf[3:4];
      expQ.push_back(EV_VAL);
      sendBuf(0);
      total++;
      if (frameValid !== 1'b1 || errTimeout !== 1'b0) begin
         bad++;
         $display("FAIL to_gap got=%b%b want=10", frameValid, errTimeout);
      end
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
      drainCheck("timeout");
   endtask

   task automatic test_overrun;
      txBuf = {8'hA5, 8'h02, 8'hC3, 8'h3C};
      txBuf.push_back(frameChk());
      expQ.push_back(EV_VAL);
      sendBuf(0);
      txBuf = {8'h77};
      expQ.push_back(EV_OVR);
      sendBuf(0);
      total++;
      if (errOverrun !== 1'b1 || frameValid !== 1'b1) begin
         bad++;
         $display("FAIL ovr got=%b%b want=11", errOverrun, frameValid);
      end
      for (int a = 0; a < 2; a++) begin
         rdAddr = 4'(a);
         @(negedge clk);
         total++;
         if (rdData !== (a == 0 ? 8'hC3 : 8'h3C)) begin
            bad++;
            $display("FAIL ovr_rd%0d got=%h", a, rdData);
         end
      end
      expQ.push_back(EV_OVR);
      rxDv = 1'b1;
      rxByte = 8'h88;
      frameAck = 1'b1;
      @(negedge clk);
      rxDv = 1'b0;
      frameAck = 1'b0;
      total++;
      if (errOverrun !== 1'b1 || isIdle !== 1'b1 || frameValid !== 1'b0) begin
         bad++;
         $display("FAIL ovr_ack got=%b%b%b want=110",
                  errOverrun, isIdle, frameValid);
      end
      drainCheck("overrun");
   endtask

   task automatic test_back_to_back;
      txBuf = {8'hA5, 8'h10};
      for (int i = 0; i < 16; i++) txBuf.push_back(8'((i * 37 + 5) & 255));
      txBuf.push_back(frameChk());
      expQ.push_back(EV_VAL);
      sendBuf(0);
      total++;
      if (frameValid !== 1'b1 || frameLen !== 5'd16) begin
         bad++;
         $display("FAIL b2b_len got=%b/%0d want=1/16", frameValid, frameLen);
      end
      for (int a = 0; a < 16; a++) begin
         rdAddr = 4'(a);
         @(negedge clk);
         total++;
         if (rdData !== sent[2 + a]) begin
            bad++;
            $display("FAIL b2b_rd%0d got=%h want=%h", a, rdData, sent[2 + a]);
         end
      end
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
      drainCheck("b2b");
   endtask

   task automatic test_reset_enable;
      txBuf = {8'hA5, 8'h04, 8'h01, 8'h02};
      sendBuf(0);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      total++;
      if ({frameValid, frameLen, rdData, errChk, errLen, errTimeout,
           errOverrun, isIdle} !== 19'd1) begin
         bad++;
         $display("FAIL rst_mid got=%h want=1", {frameValid, frameLen,
                  rdData, errChk, errLen, errTimeout, errOverrun, isIdle});
      end
      txBuf = {8'hA5, 8'h03, 8'h01};
      sendBuf(0);
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      total++;
      if (isIdle !== 1'b1) begin
         bad++;
         $display("FAIL en_mid got=%b want=1", isIdle);
      end
      txBuf = {8'hA5, 8'h01, 8'h99};
      txBuf.push_back(frameChk());
      expQ.push_back(EV_VAL);
      sendBuf(0);
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      total++;
      if (frameValid !== 1'b0 || isIdle !== 1'b1) begin
         bad++;
         $display("FAIL en_hold got=%b%b want=01", frameValid, isIdle);
      end
      txBuf = {8'hA5, 8'h01, 8'h42};
      txBuf.push_back(frameChk());
      txBuf.push_front(8'hFF);
      txBuf.push_front(8'h00);
      expQ.push_back(EV_VAL);
      rdAddr = 4'd0;
      sendBuf(1);
      total++;
      if (frameValid !== 1'b1 || frameLen !== 5'd1 || rdData !== 8'h42) begin
         bad++;
         $display("FAIL garbage got=%b/%0d/%h want=1/1/42",
                  frameValid, frameLen, rdData);
      end
      frameAck = 1'b1;
      @(negedge clk);
      frameAck = 1'b0;
      drainCheck("rsten");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_bad_length();
      test_bad_checksum();
      test_timeout();
      test_overrun();
      test_back_to_back();
      test_reset_enable();
      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame parser directly downstream of the 8N1 UART receiver. It consumes the receiver's one-cycle `rxDv` strobe and `rxByte` value, and hunts for a start-of-frame byte. It then collects a length byte, the payload and an XOR checksum, and presents a verified payload in a buffer for the command logic to read. Malformed, stalled or unconsumed traffic is reported on one-cycle error strobes and never reaches the buffer consumer.

## Interface
- `MAX_LEN`, 16: maximum payload bytes; the buffer depth.
- `SOF`, 8'hA5: start-of-frame byte value.
- `TIMEOUT_CLKS`, 12500: maximum clocks between bytes inside a frame (10 bit times at 1250 clks/bit).
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rstN`  in  1: synchronous reset, active-low.
- `en`  in  1: enable. While low, the parser holds in Idle, ignores `rxDv` and runs no timer.
- `rxDv`  in  1: byte-valid strobe from the receiver, one cycle wide.
- `rxByte`  in  8: received byte, valid when `rxDv`=1.
- `frameValid`  out  1: a verified frame is held in the buffer.
- `frameLen`  out  5: payload length of the held frame (1..`MAX_LEN`).
- `rdAddr`  in  4: payload read address.
- `rdData`  out  8: payload byte at `rdAddr`, registered.
- `frameAck`  in  1: consumer releases the held frame.
- `errChk`  out  1: one-cycle strobe, checksum mismatch.
- `errLen`  out  1: one-cycle strobe, LEN is 0 or greater than `MAX_LEN`.
- `errTimeout`  out  1: one-cycle strobe, inter-byte timeout.
- `errOverrun`  out  1: one-cycle strobe, byte received while a frame is held.
- `isIdle`  out  1: high when in Idle (hunting for SOF).

## Operation
- **Idle:**
  - `rxDv` with `rxByte`==`SOF` goes to Len.
  - Any other byte is discarded silently.
- **Len:**
  - On `rxDv`, if LEN is in 1..`MAX_LEN`: latch LEN, set running checksum = LEN, clear the write index, go to Payload.
  - Otherwise pulse `errLen` and go to Idle.
- **Payload:**
  - Each `rxDv` writes `rxByte` to buffer[index], increments index, and sets checksum ^= `rxByte`.
  - After LEN bytes, go to Check.
- **Check:**
  - On `rxDv`, if `rxByte`==checksum: go to Hold and assert `frameValid`.
  - Otherwise pulse `errChk` and go to Idle.
- **Hold:**
  - `frameValid`=1 and `frameLen`=LEN; the buffer is frozen.
  - Any `rxDv` pulses `errOverrun`; the byte is dropped and the state does not change.
  - `frameAck` goes to Idle.
- **Timeout:**
  - In Len, Payload and Check, a counter clears on every `rxDv` and increments otherwise.
  - When it reaches `TIMEOUT_CLKS`-1: pulse `errTimeout`, go to Idle.
  - Hold has no timeout.
- **`en` low:** forces Idle next cycle. A partial frame is abandoned without error, and a held frame is dropped (`frameValid` falls).
- **Arithmetic:**
  - The checksum is an 8-bit XOR over the LEN byte and all payload bytes.
  - The write index is 5 bits; buffer addresses use the low 4 bits.
- **Reads:**
  - Out-of-range `rdAddr` (≥`frameLen`) returns stale buffer content; this is not an error.

## Timing
- **Reset values:** state Idle, `frameValid`=0, `frameLen`=0, `rdData`=0, all error strobes 0, `isIdle`=1, checksum and counters 0. Buffer contents are not reset.
- **Latency:**
  - `frameValid` rises the cycle after the checksum byte's `rxDv`.
  - Each error strobe is high exactly the cycle after its cause.
- **`rdData`:** reflects `rdAddr` with 1-cycle latency.
- **Release:** `frameAck` is sampled only in Hold; `frameValid` falls the next cycle. `frameAck` outside Hold is ignored.
- **Simultaneous `frameAck` and `rxDv` in Hold:** the ack wins, the byte is dropped, and `errOverrun` pulses.
- **Simultaneous timeout expiry and `rxDv`:** the `rxDv` wins and the counter clears.
- **`rxDv` at its fastest** (back-to-back cycles) must be accepted without loss.
- **Priority order:** `rstN` low, then `en` low, then state logic.

## Structure
- Package `uart_pkg` holds:
  - the state encoding (Idle, Len, Payload, Check, Hold; 3 bits);
  - the default `SOF` constant;
  - the `CLKS_PER_BIT` constant shared with the receiver (1250), from which `TIMEOUT_CLKS` derives as 10×.
- Sub-module `uart_frame_buf`: `MAX_LEN`×8 simple dual-port memory with one write port and a registered read port. It has no reset.
- Top level: FSM, checksum register, index and timeout counters, and strobe registers.

## Test plan
- **Good frame:** A5 03 11 22 33 with checksum 03^11^22^33=03. Expect `frameValid`=1, `frameLen`=3; reads at 0,1,2 give 11,22,33; `frameAck` clears `frameValid`.
- **Bad length:** A5 00, then A5 11 (17). Expect `errLen` twice, `isIdle` after each, and no `frameValid`.
- **Bad checksum:** A5 02 AA 55 00 (expected FD). Expect a single `errChk` pulse; a following good frame is accepted.
- **Timeout:** A5 02 AA, then 12500 idle clocks. Expect `errTimeout` exactly once, then Idle. A gap of 12499 clocks must not time out.
- **Overrun:** a held frame plus byte 77. Expect `errOverrun`, and the buffer still reads the original payload. `frameAck` coinciding with `rxDv` gives Idle plus `errOverrun`.
- **Reset and enable mid-frame:** `rstN` low during Payload returns all outputs to reset values. `en` low during Hold drops `frameValid` with no error strobe. Leading garbage 00 FF before A5 is discarded.
